// File: rtl/sync_ram_512x8_pkg.sv
// sync_ram_512x8_pkg: default geometry and word type for the 512x8 buffer RAM
package sync_ram_512x8_pkg;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DEPTH      = 512;
    localparam int DEF_DATA_WIDTH = 8;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/sync_ram_512x8.sv
// sync_ram_512x8: simple-dual-port RAM, registered read-before-write output,
// whole-array synchronous clear and same-address collision flag
module sync_ram_512x8
    import sync_ram_512x8_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  error_flag
);
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    always_comb begin
        rd_data_d = rd_enb ? mem_q[rd_addr] : rd_data_q;
        err_d     = wr_enb && rd_enb && (wr_addr == rd_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_enb) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The read samples mem_q before this edge's write lands, giving the old word on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign error_flag = err_q;
endmodule

// File: tb/tb_sync_ram_512x8.sv
// tb_sync_ram_512x8: randomized scoreboard bench against an array reference model
module tb_sync_ram_512x8;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_enb = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_enb = 1'b0;
    logic [8:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       error_flag;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_mem [0:511];
    logic [7:0] ref_rd = '0;
    int         checks = 0;
    int         errors = 0;

    sync_ram_512x8 dut (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data), .error_flag(error_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rs, input logic we, input logic [8:0] wa,
                        input logic [7:0] wd, input logic re, input logic [8:0] ra);
        exp_t x;
        @(negedge clk);
        rst = rs; wr_enb = we; wr_addr = wa; wr_data = wd; rd_enb = re; rd_addr = ra;
        if (rs) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
            ref_rd = 8'h00;
            x.e = 1'b0;
        end else begin
            if (re) ref_rd = ref_mem[ra];
            x.e = we && re && (wa == ra);
            if (we) ref_mem[wa] = wd;
        end
        x.d = ref_rd;
        q.push_back(x);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (rd_data !== e.d) begin
                    errors++;
                    $display("FAIL rd_data got %h exp %h at %0t", rd_data, e.d, $time);
                end
                checks++;
                if (error_flag !== e.e) begin
                    errors++;
                    $display("FAIL error_flag got %b exp %b at %0t", error_flag, e.e, $time);
                end
            end
        end
    end

    initial begin
        logic [8:0] a[5];
        logic [8:0] wa, ra;
        step(1, 1, 9'd3, 8'hFF, 1, 9'd3);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            a[i] = 9'($urandom_range(0, 14));
            step(0, 1, a[i], 8'($urandom), 0, 0);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, a[i]);
        step(0, 1, 9'd55, 8'hA5, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9'd55);
        step(0, 1, 9'd7, 8'h3C, 0, 0);
        step(0, 0, 0, 0, 1, 9'd7);
        for (int i = 0; i < 3; i++) step(0, 1, 9'(100 + i), 8'(i + 1), 0, 0);
        step(0, 1, 9'd4, 8'h11, 0, 0);
        step(0, 1, 9'd9, 8'h22, 1, 9'd4);
        step(0, 0, 0, 0, 1, 9'd9);
        step(0, 1, 9'd5, 8'h10, 0, 0);
        step(0, 1, 9'd5, 8'h99, 1, 9'd5);
        step(0, 0, 0, 0, 1, 9'd5);
        step(0, 1, 9'd511, 8'h5A, 1, 9'd0);
        step(0, 0, 0, 0, 1, 9'd511);
        for (int i = 0; i < 3000; i++) begin
            wa = 9'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, 31));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wa, 8'($urandom),
                 $urandom_range(0, 2) != 0, ra);
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
